apb_wait_regfile_slave: RTL and testbench

- APB2 completer (slave) holding a small byte-wide register file with a programmable number of wait states and error signalling.
- Sits directly downstream of the APB master on the shared PADDR[7:0]/PWDATA/PWRITE/PENABLE bus, selected by its own PSEL line.
- Returns PRDATA, PREADY and PSLVERR for the top-level response multiplexer.
- Unlike the existing zero-wait slaves, it stretches the access phase so that the master's PREADY wait path is exercised.

---
 rtl/apb_wait_regfile_slave.sv | 168 ++++++++++++++++
 tb/tb_apb_wait_regfile_slave.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/apb_wait_regfile_slave.sv
// APB2 completer with a byte register file, programmable access-phase wait states and PSLVERR.
// Optional macro APB_SLV_XFER_CNT_EN turns register DEPTH-1 into a read-only completed-transfer counter.
module apb_wait_regfile_slave #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic       PCLK,
    input  logic       PRST,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] addr_q;
    logic       write_q;
    logic       err_q;
    logic [7:0] prdata_q;
    logic       pready_q;
    logic       pslverr_q;

    logic [7:0] rd_arr [DEPTH];

    logic       setup_hit;
    logic [7:0] cur_addr;
    logic       cur_write;
    logic       cur_err;
    logic [7:0] rd_data;
    logic       commit;

    // With zero wait states PREADY rises on the setup edge, so the live bus must be decoded.
    always_comb begin
        setup_hit = (state_q == S_IDLE) && PSEL && !PENABLE;
        cur_addr  = setup_hit ? PADDR  : addr_q;
        cur_write = setup_hit ? PWRITE : write_q;
        cur_err   = ({1'b0, cur_addr} >= 9'(DEPTH)) || (cur_write && (cur_addr == 8'd0));
`ifdef APB_SLV_XFER_CNT_EN
        if (cur_write && (cur_addr == 8'(DEPTH - 1))) begin
            cur_err = 1'b1;
        end
`endif
        rd_data   = cur_err ? 8'd0 : rd_arr[cur_addr[AW-1:0]];
        commit    = (state_q == S_DONE) && write_q && !err_q;
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 8'd0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= 8'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (setup_hit) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        err_q   <= cur_err;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= S_DONE;
                            pready_q  <= 1'b1;
                            pslverr_q <= cur_err;
                            if (!PWRITE) begin
                                prdata_q <= rd_data;
                            end
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!PSEL) begin
                        state_q <= S_IDLE;
                    end else if (PENABLE) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q   <= S_DONE;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_q;
                            if (!write_q) begin
                                prdata_q <= rd_data;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef APB_SLV_XFER_CNT_EN
    logic [7:0] xfer_cnt_q;
    logic [7:0] xfer_cnt_d;

    // Counted on the completion edge, so a read of the counter sees the pre-transfer value.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if ((state_q == S_DONE) && !err_q && (xfer_cnt_q != 8'hFF)) begin
            xfer_cnt_d = xfer_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            xfer_cnt_q <= 8'd0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_id
                assign rd_arr[gi] = ID_VALUE;
            end
`ifdef APB_SLV_XFER_CNT_EN
            else if (gi == DEPTH - 1) begin : g_cnt
                assign rd_arr[gi] = xfer_cnt_q;
            end
`endif
            else begin : g_store
                logic [7:0] data_q;
                always_ff @(posedge PCLK) begin
                    if (PRST) begin
                        data_q <= 8'd0;
                    end else if (commit && (addr_q == 8'(gi))) begin
                        data_q <= PWDATA;
                    end
                end
                assign rd_arr[gi] = data_q;
            end
        end
    endgenerate

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_wait_regfile_slave.sv
// Directed bench for apb_wait_regfile_slave: one WAIT_CYCLES=2 instance (a) and one WAIT_CYCLES=0 instance (b).
module tb_apb_wait_regfile_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       psel_a, psel_b;
    logic       penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata_a, prdata_b;
    logic       pready_a, pready_b;
    logic       pslverr_a, pslverr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_wait_regfile_slave #(.DEPTH(64), .WAIT_CYCLES(2), .ID_VALUE(8'hA5)) u_dut_a (
        .PCLK(clk), .PRST(rst), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
    );

    apb_wait_regfile_slave #(.DEPTH(64), .WAIT_CYCLES(0), .ID_VALUE(8'hA5)) u_dut_b (
        .PCLK(clk), .PRST(rst), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; back-to-back calls give a setup cycle right after the PREADY cycle.
    task automatic txn(input string tag, input bit use_b, input bit wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input int exp_lat, input logic exp_err,
                       input bit chk_rd, input logic [7:0] exp_rd);
        int         lat;
        bit         got;
        logic [7:0] rdata;
        logic       err;
        psel_a  = !use_b;
        psel_b  = use_b;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0;
        got = 1'b0;
        rdata = 8'hxx;
        err = 1'bx;
        while (!got && lat <= 20) begin
            @(negedge clk);
            if ((use_b ? pready_b : pready_a) === 1'b1) begin
                got   = 1'b1;
                rdata = use_b ? prdata_b : prdata_a;
                err   = use_b ? pslverr_b : pslverr_a;
            end else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        if (!got) lat = 99;
        @(posedge clk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        $display("txn %s: dut=%s %s addr=%0d wdata=%h rdata=%h slverr=%b wait=%0d",
                 tag, use_b ? "b" : "a", wr ? "WR" : "RD", addr, wdata, rdata, err, lat);
        check({tag, "_wait"}, 32'(lat), 32'(exp_lat));
        check({tag, "_slverr"}, {31'd0, err}, {31'd0, exp_err});
        if (chk_rd) check({tag, "_rdata"}, {24'd0, rdata}, {24'd0, exp_rd});
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'd0;
        pwdata  = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic expect_no_ready(input string tag, input int ncyc);
        int highs;
        highs = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (pready_a !== 1'b0) highs++;
        end
        @(posedge clk); #1;
        check(tag, 32'(highs), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_prdata_a", {24'd0, prdata_a}, 32'h0);
        check("rst_pready_a", {31'd0, pready_a}, 32'h0);
        check("rst_pslverr_a", {31'd0, pslverr_a}, 32'h0);
        check("rst_pready_b", {31'd0, pready_b}, 32'h0);
        @(posedge clk); #1;

        txn("rd_id", 1'b0, 1'b0, 8'd0, 8'h00, 2, 1'b0, 1'b1, 8'hA5);
        @(negedge clk);
        check("pready_one_cycle", {31'd0, pready_a}, 32'h0);
        @(posedge clk); #1;

        txn("wr5", 1'b0, 1'b1, 8'd5, 8'h3C, 2, 1'b0, 1'b0, 8'h00);
        txn("rd5", 1'b0, 1'b0, 8'd5, 8'h00, 2, 1'b0, 1'b1, 8'h3C);
        txn("rd6", 1'b0, 1'b0, 8'd6, 8'h00, 2, 1'b0, 1'b1, 8'h00);
        txn("rd4", 1'b0, 1'b0, 8'd4, 8'h00, 2, 1'b0, 1'b1, 8'h00);

        txn("wr0_err", 1'b0, 1'b1, 8'd0, 8'h11, 2, 1'b1, 1'b0, 8'h00);
        txn("rd0_after", 1'b0, 1'b0, 8'd0, 8'h00, 2, 1'b0, 1'b1, 8'hA5);
        txn("rd70_err", 1'b0, 1'b0, 8'd70, 8'h00, 2, 1'b1, 1'b1, 8'h00);
        txn("rd64_err", 1'b0, 1'b0, 8'd64, 8'h00, 2, 1'b1, 1'b1, 8'h00);
        txn("wr64_err", 1'b0, 1'b1, 8'd64, 8'h99, 2, 1'b1, 1'b0, 8'h00);

        // Abort: PSEL dropped in the first access cycle.
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'h77;
        @(posedge clk); #1;
        psel_a = 1'b0; penable = 1'b0;
        expect_no_ready("abort_psel_noready", 5);
        txn("rd9_after_abort", 1'b0, 1'b0, 8'd9, 8'h77, 2, 1'b0, 1'b1, 8'h00);

        // Abort: reset asserted in the second access cycle.
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel_a = 1'b0; penable = 1'b0;
        expect_no_ready("abort_rst_noready", 5);
        txn("rd9_after_rst", 1'b0, 1'b0, 8'd9, 8'h77, 2, 1'b0, 1'b1, 8'h00);

        // Zero-wait instance, back-to-back.
        txn("b_wr1", 1'b1, 1'b1, 8'd1, 8'h21, 0, 1'b0, 1'b0, 8'h00);
        txn("b_wr2", 1'b1, 1'b1, 8'd2, 8'h42, 0, 1'b0, 1'b0, 8'h00);
        txn("b_wr3", 1'b1, 1'b1, 8'd3, 8'h63, 0, 1'b0, 1'b0, 8'h00);
        txn("b_rd1", 1'b1, 1'b0, 8'd1, 8'h00, 0, 1'b0, 1'b1, 8'h21);
        txn("b_rd2", 1'b1, 1'b0, 8'd2, 8'h00, 0, 1'b0, 1'b1, 8'h42);
        txn("b_rd3", 1'b1, 1'b0, 8'd3, 8'h00, 0, 1'b0, 1'b1, 8'h63);
        txn("b_rd0", 1'b1, 1'b0, 8'd0, 8'h00, 0, 1'b0, 1'b1, 8'hA5);
        txn("b_rd65_err", 1'b1, 1'b0, 8'd65, 8'h00, 0, 1'b1, 1'b1, 8'h00);

        do_reset();
`ifdef APB_SLV_XFER_CNT_EN
        txn("c_wr1", 1'b0, 1'b1, 8'd1, 8'h10, 2, 1'b0, 1'b0, 8'h00);
        txn("c_wr2", 1'b0, 1'b1, 8'd2, 8'h20, 2, 1'b0, 1'b0, 8'h00);
        txn("c_rd1", 1'b0, 1'b0, 8'd1, 8'h00, 2, 1'b0, 1'b1, 8'h10);
        txn("c_wr0_err", 1'b0, 1'b1, 8'd0, 8'h55, 2, 1'b1, 1'b0, 8'h00);
        txn("c_rd63", 1'b0, 1'b0, 8'd63, 8'h00, 2, 1'b0, 1'b1, 8'h03);
        txn("c_wr63_err", 1'b0, 1'b1, 8'd63, 8'h5A, 2, 1'b1, 1'b0, 8'h00);
        txn("c_rd63_again", 1'b0, 1'b0, 8'd63, 8'h00, 2, 1'b0, 1'b1, 8'h04);
`else
        txn("rd5_cleared", 1'b0, 1'b0, 8'd5, 8'h00, 2, 1'b0, 1'b1, 8'h00);
        txn("wr63", 1'b0, 1'b1, 8'd63, 8'h5A, 2, 1'b0, 1'b0, 8'h00);
        txn("rd63", 1'b0, 1'b0, 8'd63, 8'h00, 2, 1'b0, 1'b1, 8'h5A);
        txn("rd62", 1'b0, 1'b0, 8'd62, 8'h00, 2, 1'b0, 1'b1, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
